// File: rtl/draw_mgr_pkg.sv
// Shared definitions for the draw manager: native raster size, framebuffer
// address width and the scheduler state encoding.
package draw_mgr_pkg;

    localparam int NATIVE_DRAW_WIDTH  = 640;
    localparam int NATIVE_DRAW_HEIGHT = 480;
    localparam int FB_ADDRW           = 19;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_START,
        DRAWING,
        DONE
    } draw_sched_state_t;

endpackage

// File: rtl/draw_pixel_gate.sv
// Combinational pixel gate: signed bounds check plus shift-add linear address
// (y*640+x built as (y<<9)+(y<<7)+x so no multiplier is inferred).
module draw_pixel_gate
    import draw_mgr_pkg::*;
(
    input  logic signed [31:0]         x,
    input  logic signed [31:0]         y,
    input  logic                       transparent,
    output logic                       valid,
    output logic [FB_ADDRW-1:0]        addr
);

    logic [FB_ADDRW-1:0] x_lo;
    logic [FB_ADDRW-1:0] y_lo;

    always_comb begin
        x_lo  = x[FB_ADDRW-1:0];
        y_lo  = y[FB_ADDRW-1:0];
        valid = (transparent == 1'b0) &&
                (x >= 0) && (x < NATIVE_DRAW_WIDTH) &&
                (y >= 0) && (y < NATIVE_DRAW_HEIGHT);
        // Only in-range coordinates are ever written, so 19-bit arithmetic suffices
        addr  = (y_lo << 9) + (y_lo << 7) + x_lo;
    end

endmodule

// File: rtl/draw_source_scheduler.sv
// Per-frame draw-bus scheduler: grants the shared write bus to enabled sources
// in ascending ID order. Optional start-wait timeout via DRAW_MGR_TIMEOUT_EN.
module draw_source_scheduler
    import draw_mgr_pkg::*;
#(
    parameter  int NUM_SOURCES    = 2,
    parameter  int COLOR_DEPTH    = 9,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int SELW           = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    frame,
    input  logic [NUM_SOURCES-1:0]  source_enable,
    output logic [SELW-1:0]         write_source_sel,
    output logic                    write_awaited,
    input  logic                    write_active,
    input  logic [COLOR_DEPTH-1:0]  write_color_data,
    input  logic                    write_transparent,
    input  logic signed [31:0]      write_x_addr,
    input  logic signed [31:0]      write_y_addr,
    output logic                    fb_we,
    output logic [FB_ADDRW-1:0]     fb_addr,
    output logic [COLOR_DEPTH-1:0]  fb_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int IDXW = $clog2(NUM_SOURCES + 1);

    draw_sched_state_t      state, state_next;
    logic [IDXW-1:0]        idx, idx_next;
    logic [NUM_SOURCES-1:0] en_q, en_next;
    logic [SELW-1:0]        sel_next;
    logic                   accept;
    logic                   pix_valid;
    logic [FB_ADDRW-1:0]    pix_addr;

`ifdef DRAW_MGR_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] wait_cnt;
    logic            timeout_fire;
    logic            timeout_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state            <= IDLE;
            idx              <= '0;
            en_q             <= '0;
            write_source_sel <= '0;
        end else begin
            state            <= state_next;
            idx              <= idx_next;
            en_q             <= en_next;
            write_source_sel <= sel_next;
        end
    end

    // A bus value other than a clean 1 on write_active falls into the else branches
    always_comb begin
        state_next = state;
        idx_next   = idx;
        en_next    = en_q;
        sel_next   = write_source_sel;
        accept     = 1'b0;
`ifdef DRAW_MGR_TIMEOUT_EN
        timeout_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (frame) begin
                    en_next    = source_enable;
                    idx_next   = '0;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (idx >= IDXW'(NUM_SOURCES)) begin
                    state_next = DONE;
                end else if (!en_q[idx[SELW-1:0]]) begin
                    idx_next = idx + IDXW'(1);
                end else begin
                    sel_next   = idx[SELW-1:0];
                    state_next = WAIT_START;
                end
            end
            WAIT_START: begin
                if (write_active) begin
                    accept     = 1'b1;
                    state_next = DRAWING;
                end
`ifdef DRAW_MGR_TIMEOUT_EN
                else if (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_fire = 1'b1;
                    idx_next     = idx + IDXW'(1);
                    state_next   = SELECT;
                end
`endif
            end
            DRAWING: begin
                if (write_active) begin
                    accept = 1'b1;
                end else begin
                    idx_next   = idx + IDXW'(1);
                    state_next = SELECT;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign write_awaited = (state == WAIT_START);
    assign busy          = (state != IDLE);
    assign frame_done    = (state == DONE);

    draw_pixel_gate u_gate (
        .x           (write_x_addr),
        .y           (write_y_addr),
        .transparent (write_transparent),
        .valid       (pix_valid),
        .addr        (pix_addr)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept && pix_valid) begin
                fb_we   <= 1'b1;
                fb_addr <= pix_addr;
                fb_data <= write_color_data;
            end else begin
                fb_we   <= 1'b0;
            end
            if (frame && state != IDLE)
                overrun <= 1'b1;
        end
    end

`ifdef DRAW_MGR_TIMEOUT_EN
    // Counter restarts every time WAIT_START is entered from another state
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != WAIT_START)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CNTW'(1);
            if (timeout_fire)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/draw_source_scheduler.md
# draw_source_scheduler

Per-frame scheduler that shares the draw-manager write bus between draw sources, such as the starfield and sprite units. On each `frame` pulse it grants the bus to each enabled source in ascending ID order and handshakes with it over `write_source_sel`/`write_awaited`. Every accepted pixel it forwards is range-checked and converted to a linear framebuffer write. It sits between the draw sources and the framebuffer RAM write port.

## Interface
Parameters:
- `NUM_SOURCES`, 2: number of draw sources; IDs are 0..NUM_SOURCES-1.
- `COLOR_DEPTH`, 9: pixel colour width.
- `TIMEOUT_CYCLES`, 1024: start-wait limit per source; used only with `DRAW_MGR_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset; synchronous, active-low.
- `frame`  in  1  one-cycle start-of-frame pulse.
- `source_enable`  in  NUM_SOURCES  per-source enable mask, sampled when a frame is accepted.
- `write_source_sel`  out  max(1,$clog2(NUM_SOURCES))  ID of the granted source.
- `write_awaited`  out  1  scheduler is waiting for the granted source to start.
- `write_active`  in  1  shared bus; source is emitting a pixel this cycle.
- `write_color_data`  in  COLOR_DEPTH  shared bus pixel colour.
- `write_transparent`  in  1  shared bus; pixel must not be written.
- `write_x_addr`  in  32  signed pixel x coordinate.
- `write_y_addr`  in  32  signed pixel y coordinate.
- `fb_we`  out  1  framebuffer write enable.
- `fb_addr`  out  19  linear address, y*640+x.
- `fb_data`  out  COLOR_DEPTH  framebuffer write data.
- `busy`  out  1  a frame pass is in progress.
- `frame_done`  out  1  one-cycle pulse when a pass completes.
- `overrun`  out  1  sticky; a frame pulse arrived while busy. Cleared only by reset.
- `timeout_err`  out  1  sticky; a source timed out (`DRAW_MGR_TIMEOUT_EN` only).

## Operation
State machine states are IDLE, SELECT, WAIT_START, DRAWING, DONE.
- **IDLE:** on `frame`, latch `source_enable` into `en_q`, set idx=0, go to SELECT.
- **SELECT:** if idx ≥ NUM_SOURCES, go to DONE.
  - Else if `en_q[idx]`=0, increment idx and stay in SELECT. Each skipped source costs one cycle.
  - Else drive `write_source_sel`=idx and go to WAIT_START.
- **WAIT_START:** `write_awaited`=1.
  - `write_active`==1 → DRAWING; that cycle's pixel is forwarded.
  - Any non-1 value, including z or x, counts as inactive.
- **DRAWING:** `write_awaited`=0. Every cycle with `write_active`=1 forwards a pixel.
  - The first cycle with `write_active`≠1 → increment idx and go to SELECT.
- **DONE:** pulse `frame_done`, go to IDLE.
- `write_source_sel` holds its last value outside WAIT_START and DRAWING.
- **Pixel gate.** A write is issued iff `write_transparent`=0, 0≤x<640 and 0≤y<480, with both coordinates compared as signed 32-bit values.
  - Address is formed as (y<<9)+(y<<7)+x, truncated to 19 bits.
  - No multiplier.
- A `frame` pulse in any state other than IDLE sets `overrun` and is otherwise ignored.
- A `frame` pulse in the same cycle as DONE is also an overrun.

## Timing
- Reset values: state IDLE; `write_source_sel`=0, `write_awaited`=0, `fb_we`=0, `fb_addr`=0, `fb_data`=0; `busy`=0, `frame_done`=0, `overrun`=0, `timeout_err`=0.
- Reset asserted mid-pass aborts immediately. The next clock edge yields all reset values, and no further `fb_we` is issued.
- `busy`=1 in SELECT, WAIT_START, DRAWING and DONE.
- Framebuffer outputs are registered: a bus pixel accepted at edge N appears on `fb_*` after edge N+1.
- Grant latency: SELECT→WAIT_START takes one cycle, and `write_awaited` is visible the cycle after idx is chosen.
- Minimum pass with all sources disabled: IDLE→SELECT ×(NUM_SOURCES+1)→DONE.

## Configuration
- **`DRAW_MGR_TIMEOUT_EN` defined:**
  - A counter runs in WAIT_START.
  - When it reaches TIMEOUT_CYCLES without `write_active`, `timeout_err` is set, idx is incremented and the FSM returns to SELECT.
  - The counter clears on each entry to WAIT_START.
- **Not defined:**
  - WAIT_START waits indefinitely.
  - `timeout_err` is tied to 0 and no counter logic is generated.

## Structure
- Package `draw_mgr_pkg`:
  - `NATIVE_DRAW_WIDTH`=640, `NATIVE_DRAW_HEIGHT`=480, `FB_ADDRW`=19.
  - State enum `draw_sched_state_t`.
  - Shared by draw sources and this block.
- Sub-module `draw_pixel_gate`:
  - Combinational bounds check plus shift-add address.
  - Feeds the `fb_*` output registers.

## Test plan
- **Single source.** NUM_SOURCES=2, mask=2'b01; source 0 bursts 50 pixels at (10,20) → 50 `fb_we` at addr 12810; `frame_done` pulses once; source 1 is never selected.
- **Pixel gate.** Pixels at x=-1, x=640, y=480 and with transparent=1 → no `fb_we`. A pixel at (639,479) → addr 307199.
- **Ordering.** Both sources enabled, burst lengths 3 and 5 → sel=0, then sel=1; 8 writes in order; `write_awaited` low throughout DRAWING.
- **Overrun.** `frame` pulse during DRAWING → `overrun`=1 and the pass is unaffected. Next `frame` in IDLE starts a new pass.
- **Reset mid-pass.** `resetN`=0 during DRAWING → all outputs at reset values after the next edge. A new `frame` then restarts from source 0.
- **Timeout** (with `DRAW_MGR_TIMEOUT_EN`, TIMEOUT_CYCLES=16). Source 0 never responds → after 16 cycles `timeout_err`=1, source 1 is drawn, and `frame_done` still pulses.
